slave_read_arbiter: RTL

SLAVE_READ_ARBITER -- requirements
Module: slave_read_arbiter

---
 rtl/slave_read_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/slave_read_arbiter.sv
// -----------------------------------------------------------------------------
// slave_read_arbiter
//
// Round-robin read-channel arbiter for one slave. Several masters request the
// slave through REQ. One master wins and keeps the slave from the address
// phase through the last beat of its read burst. After that the arbiter goes
// back to IDLE and arbitrates again.
//
// Parameters
//   NUM_M     number of competing masters
//   ID_W      width of the encoded grant index (must be >= clog2(NUM_M))
//
// Ports
//   ACLK      clock; all state changes on its rising edge
//   ARESET    asynchronous, active-high reset
//   REQ       per-master read request for this slave
//   ARREADY_S slave accepts the read address
//   RVALID_S  slave drives valid read data
//   RLAST_S   last beat of the read burst
//   RREADY_M  per-master read-data ready
//   GRANT     one-hot grant (all zero when idle)
//   GRANT_ID  encoded index of the granted master (0 when idle)
//   ARVALID_S request forwarded to the slave while in ADDR
//   BUSY      high while a transaction owns the slave (ADDR or DATA)
// -----------------------------------------------------------------------------
module slave_read_arbiter #(
  parameter int NUM_M = 3,
  parameter int ID_W  = 2
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [NUM_M-1:0] REQ,
  input  logic             ARREADY_S,
  input  logic             RVALID_S,
  input  logic             RLAST_S,
  input  logic [NUM_M-1:0] RREADY_M,
  output logic [NUM_M-1:0] GRANT,
  output logic [ID_W-1:0]  GRANT_ID,
  output logic             ARVALID_S,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [NUM_M-1:0] grant_nxt;
  logic [ID_W-1:0]  grant_id_nxt;
  logic [ID_W-1:0]  last_granted, last_granted_nxt;

  logic             rr_found;
  logic [ID_W-1:0]  rr_winner;

  // Round-robin search. It starts one past the last granted master and wraps
  // modulo NUM_M. The first requester found wins, so at most one bit of the
  // grant is ever set.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, otherwise paths that skip the assignment infer a latch.
    rr_found  = 1'b0;
    rr_winner = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (!rr_found && REQ[(int'(last_granted) + 1 + i) % NUM_M]) begin
        rr_found  = 1'b1;
        rr_winner = ID_W'((int'(last_granted) + 1 + i) % NUM_M);
      end
    end
  end

  // The slave sees the granted master's live request only during the address
  // phase. When that request drops, ARVALID_S falls in the same cycle.
  assign ARVALID_S = (state == ADDR) && REQ[GRANT_ID];
  assign BUSY      = (state != IDLE);

  // Next-state and next-grant logic
  always_comb begin
    state_nxt        = state;
    grant_nxt        = GRANT;
    grant_id_nxt     = GRANT_ID;
    last_granted_nxt = last_granted;

    unique case (state)
      IDLE: begin
        if (rr_found) begin
          state_nxt            = ADDR;
          grant_nxt            = '0;
          grant_nxt[rr_winner] = 1'b1;
          grant_id_nxt         = rr_winner;
          // The rotation pointer moves only when a grant is actually issued.
          last_granted_nxt     = rr_winner;
        end
      end

      ADDR: begin
        if (!REQ[GRANT_ID]) begin
          // The requester withdrew before the handshake. Release the slave
          // but keep the rotation pointer as it is.
          state_nxt    = IDLE;
          grant_nxt    = '0;
          grant_id_nxt = '0;
        end else if (ARREADY_S) begin
          state_nxt = DATA;
        end
      end

      DATA: begin
        // The grant is held against all new requests until the granted master
        // accepts the last beat.
        if (RVALID_S && RREADY_M[GRANT_ID] && RLAST_S) begin
          state_nxt    = IDLE;
          grant_nxt    = '0;
          grant_id_nxt = '0;
        end
      end

      default: begin
        state_nxt    = IDLE;
        grant_nxt    = '0;
        grant_id_nxt = '0;
      end
    endcase
  end

  // State register. Reset aborts any transaction at once, without a clock.
  // It also makes master 0 the first priority by pointing the rotation at
  // the last master.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state        <= IDLE;
      GRANT        <= '0;
      GRANT_ID     <= '0;
      last_granted <= ID_W'(NUM_M - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so all registers
      // update together from values sampled at the same edge.
      state        <= state_nxt;
      GRANT        <= grant_nxt;
      GRANT_ID     <= grant_id_nxt;
      last_granted <= last_granted_nxt;
    end
  end

endmodule
